div_seq: RTL and testbench
==========================

Name: div_seq

Overview:
- Multi-cycle sequencer for a radix-2 restoring divider that sits beside the EX stage.
- EX issues a divide with a level-held start. The block requests a pipeline stall, iterates one quotient bit per clock, and returns {remainder, quotient} with a ready flag.
- It owns the divider datapath state and is the only source of EX stall requests for DIV/DIVU.

Parameters:
- DATA_W, 32, operand width (matches `RegBus).
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > DATA_W.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- div_start  in  1  divide request; held high by EX until the result is consumed.
- div_signed  in  1  1 = signed (DIV), 0 = unsigned (DIVU); sampled with start in IDLE.
- div_annul  in  1  abort, e.g. a flush from an exception or branch.
- div_opdata1  in  DATA_W  dividend.
- div_opdata2  in  DATA_W  divisor.
- div_result  out  2*DATA_W  {remainder, quotient}.
- div_ready  out  1  result valid.
- stallreq  out  1  stall request to the pipeline controller.

Behaviour:
- Reset: state=IDLE, cnt=0, div_result=0, div_ready=0; internal dividend/divisor/partial-remainder registers cleared.
- stallreq (combinational) = div_start & ~div_annul & ~(state==DONE).
- State encodings: IDLE, BYZERO, ON, DONE.

IDLE:
- If div_start & ~div_annul & divisor==0: go to BYZERO.
- Else if div_start & ~div_annul:
  - latch |dividend| and |divisor| (absolute values only when div_signed, raw values otherwise);
  - latch sign flags and div_signed;
  - cnt=0; go to ON.
- Otherwise stay in IDLE.
- Operands are not resampled after leaving IDLE.

BYZERO:
- One cycle, then go to DONE.
- div_result = {dividend_raw, all-ones}, i.e. remainder=dividend, quotient=0xFFFFFFFF for both signedness modes.

ON:
- One iteration per edge: shift {rem, quo} left by 1, trial-subtract the divisor from rem.
- If non-negative: keep the difference and set quo LSB=1; else set quo LSB=0.
- cnt increments on every ON edge.
- On the edge where cnt==DATA_W-1: register the sign-corrected result into div_result, set div_ready=1, go to DONE.
- Sign correction, applied only when signed:
  - quotient negated if the operand signs differ;
  - remainder negated if the dividend was negative.

DONE:
- div_ready=1; div_result held stable.
- Stay in DONE while div_start=1.
- When div_start=0: go to IDLE, div_ready=0 next edge, div_result retains its value.

Latency:
- start sampled at edge E0 -> ON at E1..E32 -> div_ready visible after edge E(DATA_W+1), i.e. E33.
- Divide-by-zero: ready visible after E2.

Annul:
- div_annul=1 in any state other than IDLE forces IDLE at the next edge, with div_ready=0 and cnt=0.
- Annul has priority over completion and over start.

Overflow:
- Signed 0x80000000 / 0xFFFFFFFF yields quotient 0x80000000, remainder 0. This falls out of the absolute-value datapath with no special case.

Other boundaries:
- Dividend 0: quotient 0, remainder 0, full DATA_W+1 latency.
- Operand changes while busy: ignored.
- Asynchronous reset mid-operation: immediate return to reset values.

Decomposition:
- Shared defines file (`defines.v`):
  - state encodings DIV_IDLE/DIV_BYZERO/DIV_ON/DIV_DONE;
  - DivStart/DivStop and DivResultReady/DivResultNotReady constants;
  - `RegBus width;
  - new EXE_DIV_OP/EXE_DIVU_OP AluOp codes.
- One natural sub-module, div_step: combinational single-iteration shift/trial-subtract (inputs rem, quo, divisor; outputs next rem, next quo).
- The FSM, counter and sign fix-up stay in div_seq.

Test Plan:
- Unsigned 100/7, start held -> stallreq=1 through E32; div_ready after E33; div_result={0x00000002, 0x0000000E}; stallreq=0 once DONE.
- Signed -7/2 (0xFFFFFFF9/0x00000002) -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF; unsigned mode on the same operands -> quotient 0x7FFFFFFC, remainder 0x00000001.
- Divide by zero: 5/0 -> BYZERO then DONE; ready after E2; result {0x00000005, 0xFFFFFFFF}.
- Annul at E10 of a 50/5 divide -> IDLE next edge, ready never asserts. A fresh 50/5 start afterwards -> quotient 10, remainder 0 after 33 edges.
- Signed overflow 0x80000000/0xFFFFFFFF -> quotient 0x80000000, remainder 0; full latency.
- rst low at E15 mid-divide -> outputs zero immediately, state IDLE. Separately: start held 5 extra cycles in DONE -> result stable; start low -> ready drops next edge.

Source files
------------

// File: rtl/div_seq_pkg.sv
// Shared constants and types for the sequential radix-2 restoring divider.
// Mirrors the pipeline-wide defines: register bus width, FSM encodings, handshake levels, ALU op codes.
package div_seq_pkg;

  localparam int REG_BUS_W = 32;
  localparam int DIV_CNT_W = 6;

  typedef enum logic [1:0] {
    DIV_IDLE   = 2'b00,
    DIV_BYZERO = 2'b01,
    DIV_ON     = 2'b10,
    DIV_DONE   = 2'b11
  } div_state_t;

  localparam logic DIV_START            = 1'b1;
  localparam logic DIV_STOP             = 1'b0;
  localparam logic DIV_RESULT_READY     = 1'b1;
  localparam logic DIV_RESULT_NOT_READY = 1'b0;

  localparam logic [7:0] EXE_DIV_OP  = 8'b0001_1010;
  localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;

endpackage

// File: rtl/div_seq_step.sv
// One restoring-division iteration: shift {rem, quo} left, trial-subtract the divisor from rem.
// Purely combinational; the sequencer registers the outputs once per clock.
module div_seq_step #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] rem,
  input  logic [DATA_W-1:0] quo,
  input  logic [DATA_W-1:0] divisor,
  output logic [DATA_W-1:0] rem_next,
  output logic [DATA_W-1:0] quo_next
);

  // rem < divisor on entry, so the shifted value needs one extra bit and the difference one more for the borrow.
  logic [DATA_W:0]   rem_shift;
  logic [DATA_W+1:0] trial;

  always_comb begin
    rem_shift = {rem, quo[DATA_W-1]};
    trial     = {1'b0, rem_shift} - {2'b00, divisor};
    rem_next  = rem_shift[DATA_W-1:0];
    quo_next  = {quo[DATA_W-2:0], 1'b0};
    if (!trial[DATA_W+1]) begin
      rem_next = trial[DATA_W-1:0];
      quo_next = {quo[DATA_W-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/div_seq.sv
// Multi-cycle sequencer for a radix-2 restoring divider beside the EX stage.
// Stalls EX while busy, produces one quotient bit per clock, returns {remainder, quotient} with a ready flag.
module div_seq
  import div_seq_pkg::*;
#(
  parameter int DATA_W = REG_BUS_W,
  parameter int CNT_W  = DIV_CNT_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  div_start,
  input  logic                  div_signed,
  input  logic                  div_annul,
  input  logic [DATA_W-1:0]     div_opdata1,
  input  logic [DATA_W-1:0]     div_opdata2,
  output logic [2*DATA_W-1:0]   div_result,
  output logic                  div_ready,
  output logic                  stallreq,
  output div_state_t            dbg_state
);

  div_state_t        state;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] rem_r;
  logic [DATA_W-1:0] quo_r;
  logic [DATA_W-1:0] divisor_r;
  logic              dividend_neg_r;
  logic              divisor_neg_r;
  logic              signed_r;

  logic              op1_neg;
  logic              op2_neg;
  logic [DATA_W-1:0] op1_abs;
  logic [DATA_W-1:0] op2_abs;
  logic [DATA_W-1:0] rem_next;
  logic [DATA_W-1:0] quo_next;
  logic [DATA_W-1:0] quo_fixed;
  logic [DATA_W-1:0] rem_fixed;
  logic              last_iter;
  logic              start_req;

  // Handshake: EX holds div_start high until it has consumed the result; div_ready stays high
  // in DONE for as long as start is held, and EX is stalled whenever a live request is not yet DONE.
  assign start_req = (div_start == DIV_START) && !div_annul;
  assign stallreq  = start_req && (state != DIV_DONE);
  assign dbg_state = state;

  always_comb begin
    op1_neg = div_signed & div_opdata1[DATA_W-1];
    op2_neg = div_signed & div_opdata2[DATA_W-1];
    op1_abs = op1_neg ? (~div_opdata1 + 1'b1) : div_opdata1;
    op2_abs = op2_neg ? (~div_opdata2 + 1'b1) : div_opdata2;
  end

  div_seq_step #(
    .DATA_W (DATA_W)
  ) u_step (
    .rem      (rem_r),
    .quo      (quo_r),
    .divisor  (divisor_r),
    .rem_next (rem_next),
    .quo_next (quo_next)
  );

  // Most-negative / -1 needs no special case: its magnitude 2^(W-1) negates back onto itself.
  always_comb begin
    quo_fixed = quo_next;
    rem_fixed = rem_next;
    if (signed_r && (dividend_neg_r ^ divisor_neg_r)) begin
      quo_fixed = ~quo_next + 1'b1;
    end
    if (signed_r && dividend_neg_r) begin
      rem_fixed = ~rem_next + 1'b1;
    end
  end

  assign last_iter = (cnt == CNT_W'(DATA_W - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= DIV_IDLE;
      cnt            <= '0;
      rem_r          <= '0;
      quo_r          <= '0;
      divisor_r      <= '0;
      dividend_neg_r <= 1'b0;
      divisor_neg_r  <= 1'b0;
      signed_r       <= 1'b0;
      div_result     <= '0;
      div_ready      <= DIV_RESULT_NOT_READY;
    end else if (div_annul && (state != DIV_IDLE)) begin
      state     <= DIV_IDLE;
      cnt       <= '0;
      div_ready <= DIV_RESULT_NOT_READY;
    end else begin
      case (state)
        DIV_IDLE: begin
          div_ready <= DIV_RESULT_NOT_READY;
          if (start_req && (div_opdata2 == '0)) begin
            // Raw dividend is parked in quo_r so BYZERO can return it as the remainder.
            quo_r <= div_opdata1;
            state <= DIV_BYZERO;
          end else if (start_req) begin
            rem_r          <= '0;
            quo_r          <= op1_abs;
            divisor_r      <= op2_abs;
            dividend_neg_r <= op1_neg;
            divisor_neg_r  <= op2_neg;
            signed_r       <= div_signed;
            cnt            <= '0;
            state          <= DIV_ON;
          end
        end
        DIV_BYZERO: begin
          div_result <= {quo_r, {DATA_W{1'b1}}};
          div_ready  <= DIV_RESULT_READY;
          state      <= DIV_DONE;
        end
        DIV_ON: begin
          rem_r <= rem_next;
          quo_r <= quo_next;
          cnt   <= cnt + 1'b1;
          if (last_iter) begin
            div_result <= {rem_fixed, quo_fixed};
            div_ready  <= DIV_RESULT_READY;
            state      <= DIV_DONE;
          end
        end
        DIV_DONE: begin
          if (div_start == DIV_STOP) begin
            div_ready <= DIV_RESULT_NOT_READY;
            state     <= DIV_IDLE;
          end else begin
            div_ready <= DIV_RESULT_READY;
          end
        end
        default: begin
          state     <= DIV_IDLE;
          div_ready <= DIV_RESULT_NOT_READY;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_seq.sv
// Directed bench for div_seq: driver pushes hand-computed results into a queue, a monitor pops on each ready rise.
module tb_div_seq;
  import div_seq_pkg::*;

  localparam int W = 32;

  logic           clk;
  logic           rst;
  logic           div_start;
  logic           div_signed;
  logic           div_annul;
  logic [W-1:0]   div_opdata1;
  logic [W-1:0]   div_opdata2;
  logic [2*W-1:0] div_result;
  logic           div_ready;
  logic           stallreq;
  div_state_t     dbg_state;

  logic [2*W-1:0] exp_q[$];
  int             n_checks;
  int             n_pass;
  logic           ready_q;

  div_seq #(.DATA_W(W), .CNT_W(6)) dut (
    .clk         (clk),
    .rst         (rst),
    .div_start   (div_start),
    .div_signed  (div_signed),
    .div_annul   (div_annul),
    .div_opdata1 (div_opdata1),
    .div_opdata2 (div_opdata2),
    .div_result  (div_result),
    .div_ready   (div_ready),
    .stallreq    (stallreq),
    .dbg_state   (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // monitor: compare on every rising edge of div_ready
  initial ready_q = 1'b0;
  always @(negedge clk) begin
    if (div_ready && !ready_q) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_ready: got result %h, expected no response", div_result);
      end else begin
        check("result", div_result, exp_q.pop_front());
      end
    end
    ready_q = div_ready;
  end

  // driver: start right after edge E0, hold until ready, optionally linger in DONE
  task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn,
                         input logic [2*W-1:0] exp, input int exp_lat, input int hold,
                         input bit scramble);
    int lat;
    bit stall_ok;
    bit stable_ok;
    @(posedge clk); #1;
    div_opdata1 = a;
    div_opdata2 = b;
    div_signed  = sgn;
    div_start   = 1'b1;
    exp_q.push_back(exp);
    lat      = 0;
    stall_ok = 1'b1;
    for (int k = 1; k <= 100 && lat == 0; k++) begin
      @(posedge clk); #1;
      if (scramble) begin
        div_opdata1 = $urandom;
        div_opdata2 = $urandom;
        div_signed  = ~sgn;
      end
      if (div_ready) lat = k;
      else if (!stallreq) stall_ok = 1'b0;
    end
    check("latency", 64'(lat), 64'(exp_lat));
    check("stall_busy", {63'd0, stall_ok}, 64'd1);
    check("stall_done", {63'd0, stallreq}, 64'd0);
    stable_ok = 1'b1;
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      if (!div_ready || div_result !== exp) stable_ok = 1'b0;
    end
    if (hold > 0) check("done_hold", {63'd0, stable_ok}, 64'd1);
    div_start = 1'b0;
    @(posedge clk); #1;
    check("ready_drop", {63'd0, div_ready}, 64'd0);
    check("result_kept", div_result, exp);
  endtask

  initial begin
    bit quiet;
    n_checks    = 0;
    n_pass      = 0;
    rst         = 1'b0;
    div_start   = 1'b0;
    div_signed  = 1'b0;
    div_annul   = 1'b0;
    div_opdata1 = '0;
    div_opdata2 = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_result", div_result, 64'd0);
    check("rst_ready", {63'd0, div_ready}, 64'd0);
    check("rst_state", 64'(dbg_state), 64'(DIV_IDLE));
    check("rst_stall", {63'd0, stallreq}, 64'd0);
    @(negedge clk);
    rst = 1'b1;

    // unsigned 100/7 -> q 14, r 2
    run_div(32'd100, 32'd7, 1'b0, {32'h0000_0002, 32'h0000_000E}, 33, 0, 1'b0);
    // signed -7/2 -> q -3, r -1
    run_div(32'hFFFF_FFF9, 32'd2, 1'b1, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33, 0, 1'b0);
    // unsigned 4294967289/2 -> q 0x7FFFFFFC, r 1
    run_div(32'hFFFF_FFF9, 32'd2, 1'b0, {32'h0000_0001, 32'h7FFF_FFFC}, 33, 0, 1'b0);
    // divide by zero, unsigned and signed
    run_div(32'd5, 32'd0, 1'b0, {32'h0000_0005, 32'hFFFF_FFFF}, 2, 0, 1'b0);
    run_div(32'hFFFF_FFF0, 32'd0, 1'b1, {32'hFFFF_FFF0, 32'hFFFF_FFFF}, 2, 0, 1'b0);
    // signed overflow -2^31 / -1 -> q 0x80000000, r 0
    run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, {32'h0000_0000, 32'h8000_0000}, 33, 0, 1'b0);
    // -8/3 -> q -2, r -2 ; 7/-2 -> q -3, r 1
    run_div(32'hFFFF_FFF8, 32'd3, 1'b1, {32'hFFFF_FFFE, 32'hFFFF_FFFE}, 33, 0, 1'b0);
    run_div(32'd7, 32'hFFFF_FFFE, 1'b1, {32'h0000_0001, 32'hFFFF_FFFD}, 33, 0, 1'b0);
    // dividend 0, full latency
    run_div(32'd0, 32'd9, 1'b0, 64'd0, 33, 0, 1'b0);
    // operands change while busy: 1000/33 -> q 30, r 10
    run_div(32'd1000, 32'd33, 1'b0, {32'd10, 32'd30}, 33, 0, 1'b1);

    // annul sampled at E10 of a 50/5 divide, with start still high
    @(posedge clk); #1;
    div_opdata1 = 32'd50;
    div_opdata2 = 32'd5;
    div_signed  = 1'b0;
    div_start   = 1'b1;
    repeat (9) @(posedge clk);
    #1;
    div_annul = 1'b1;
    @(posedge clk); #1;
    check("annul_state", 64'(dbg_state), 64'(DIV_IDLE));
    check("annul_ready", {63'd0, div_ready}, 64'd0);
    check("annul_stall", {63'd0, stallreq}, 64'd0);
    div_start = 1'b0;
    div_annul = 1'b0;
    quiet = 1'b1;
    repeat (40) begin
      @(posedge clk); #1;
      if (div_ready) quiet = 1'b0;
    end
    check("annul_no_ready", {63'd0, quiet}, 64'd1);
    // fresh 50/5 with start held 5 extra cycles in DONE
    run_div(32'd50, 32'd5, 1'b0, {32'd0, 32'd10}, 33, 5, 1'b0);

    // asynchronous reset at E15 mid-divide
    @(posedge clk); #1;
    div_opdata1 = 32'd77;
    div_opdata2 = 32'd4;
    div_start   = 1'b1;
    repeat (15) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("arst_result", div_result, 64'd0);
    check("arst_ready", {63'd0, div_ready}, 64'd0);
    check("arst_state", 64'(dbg_state), 64'(DIV_IDLE));
    div_start = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    // back to normal operation after reset: 77/4 -> q 19, r 1
    run_div(32'd77, 32'd4, 1'b0, {32'd1, 32'd19}, 33, 0, 1'b0);

    repeat (3) @(posedge clk);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
